// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with one-entry byte buffer and cts
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active low
//   rxd        in   serial input, asynchronous, idle high
//   rx_ack     in   consumer took rx_data; clears rx_valid and overrun
//   rx_data    out  last good byte, stable while rx_valid
//   rx_valid   out  buffer full, held until rx_ack
//   frame_err  out  one-cycle pulse when the stop bit samples low
//   overrun    out  sticky: byte completed while buffer was full
//   cts        out  clear-to-send, low exactly while rx_valid is high

module uart_rx #(
   parameter int BIT_CLKS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       cts
);

   localparam int HALF = BIT_CLKS / 2;
   localparam int CW   = $clog2(BIT_CLKS);

   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);
   localparam logic [CW-1:0] CNT_A    = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_B    = CW'(HALF);
   localparam logic [CW-1:0] CNT_MID  = CW'(HALF + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          samp_a_q, samp_a_d;
   logic          samp_b_q, samp_b_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          cts_q, cts_d;

   logic          rxs;
   logic          maj;
   logic          bit_end;
   logic          mid;
   logic          deliver;
   logic [CW-1:0] cnt_next;

   assign rxs = sync2_q;
   // Third vote is the live sample; the first two were captured on the two preceding cycles.
   assign maj = (samp_a_q & samp_b_q) | (samp_a_q & rxs) | (samp_b_q & rxs);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         samp_a_q    <= 1'b1;
         samp_b_q    <= 1'b1;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         cts_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         samp_a_q    <= samp_a_d;
         samp_b_q    <= samp_b_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         cts_q       <= cts_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      sync1_d     = rxd;
      sync2_d     = sync1_q;
      samp_a_d    = samp_a_q;
      samp_b_d    = samp_b_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
      deliver     = 1'b0;

      bit_end  = (cnt_q == CNT_LAST);
      mid      = (cnt_q == CNT_MID);
      cnt_next = bit_end ? '0 : cnt_q + 1'b1;

      if (cnt_q == CNT_A) samp_a_d = rxs;
      if (cnt_q == CNT_B) samp_b_d = rxs;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxs) state_d = S_START;
         end
         S_START: begin
            cnt_d = cnt_next;
            if (mid && maj) begin
               // Low pulse shorter than half a bit: not a start bit.
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (bit_end) begin
               state_d = S_DATA;
               idx_d   = 3'd0;
            end
         end
         S_DATA: begin
            cnt_d = cnt_next;
            if (mid) shift_d[idx_q] = maj;
            if (bit_end) begin
               if (idx_q == 3'd7) state_d = S_STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         S_STOP: begin
            cnt_d = cnt_next;
            if (mid) begin
               // Leave half a bit early so a back-to-back start edge is not missed.
               cnt_d = '0;
               if (maj) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rxs) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (rx_ack && rx_valid_q) begin
         rx_valid_d = 1'b0;
         overrun_d  = 1'b0;
      end
      // An ack in the same cycle frees the buffer for the incoming byte.
      if (deliver) begin
         if (!rx_valid_q || rx_ack) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      cts_d = ~rx_valid_d;
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign cts       = cts_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

   localparam int BC = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       cts;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int fe_cnt = 0;
   int rise_cyc = 0;
   int start_cyc = 0;
   logic prev_valid = 1'b0;

   uart_rx #(.BIT_CLKS(BC)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .rx_ack(rx_ack),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
      .overrun(overrun), .cts(cts)
   );

   always #1 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
   end

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         low_tail;
      int         gap;
      logic       ack;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ovr;
      int         exp_fe;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      start_cyc = cyc;
      for (int b = 0; b < 10; b++) begin
         rxd = bits[b];
         repeat (BC) @(negedge clk);
      end
      rxd = 1'b1;
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   initial begin
      int fe0;

      //            d      stop tail gap ack valid data   ovr fe
      vecs[0] = '{8'hA5, 1'b1, 0, 4, 1'b1, 1'b1, 8'hA5, 1'b0, 0};
      vecs[1] = '{8'h3C, 1'b1, 0, 0, 1'b0, 1'b1, 8'h3C, 1'b0, 0};
      vecs[2] = '{8'hC3, 1'b1, 0, 4, 1'b1, 1'b1, 8'h3C, 1'b1, 0};
      vecs[3] = '{8'h55, 1'b0, 3, 4, 1'b0, 1'b0, 8'h3C, 1'b0, 1};
      vecs[4] = '{8'h81, 1'b1, 0, 4, 1'b1, 1'b1, 8'h81, 1'b0, 0};
      vecs[5] = '{8'hFF, 1'b1, 0, 4, 1'b1, 1'b1, 8'hFF, 1'b0, 0};
      vecs[6] = '{8'h00, 1'b1, 0, 4, 1'b1, 1'b1, 8'h00, 1'b0, 0};

      rst = 1'b0;
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset rx_data", {24'd0, rx_data}, 32'h00);
      chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset overrun", {31'd0, overrun}, 32'd0);
      chk("reset cts", {31'd0, cts}, 32'd1);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         fe0 = fe_cnt;
         send_frame(vecs[i].d, vecs[i].stop);
         if (vecs[i].low_tail > 0) begin
            rxd = 1'b0;
            repeat (vecs[i].low_tail * BC) @(negedge clk);
            rxd = 1'b1;
         end
         repeat (vecs[i].gap) @(negedge clk);
         chk($sformatf("v%0d rx_valid", i), {31'd0, rx_valid}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("v%0d rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
         chk($sformatf("v%0d overrun", i), {31'd0, overrun}, {31'd0, vecs[i].exp_ovr});
         chk($sformatf("v%0d cts", i), {31'd0, cts}, {31'd0, ~vecs[i].exp_valid});
         chk($sformatf("v%0d frame_err cycles", i), fe_cnt - fe0, vecs[i].exp_fe);
         if (i == 0) begin
            if (rise_cyc - start_cyc < 156 || rise_cyc - start_cyc > 158) begin
               n_cmp++;
               n_bad++;
               $display("FAIL latency: got %0d expected 156..158", rise_cyc - start_cyc);
            end else begin
               n_cmp++;
            end
         end
         if (vecs[i].ack) begin
            do_ack();
            chk($sformatf("v%0d ack rx_valid", i), {31'd0, rx_valid}, 32'd0);
            chk($sformatf("v%0d ack overrun", i), {31'd0, overrun}, 32'd0);
            chk($sformatf("v%0d ack cts", i), {31'd0, cts}, 32'd1);
            chk($sformatf("v%0d ack rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
         end
      end

      // Ack with nothing buffered has no effect.
      do_ack();
      chk("idle ack rx_valid", {31'd0, rx_valid}, 32'd0);

      // 5-cycle low glitch: no byte, no flag, receiver still takes the next frame.
      fe0 = fe_cnt;
      rxd = 1'b0;
      repeat (5) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * BC) @(negedge clk);
      chk("glitch rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("glitch frame_err", fe_cnt - fe0, 32'd0);
      send_frame(8'h5A, 1'b1);
      repeat (4) @(negedge clk);
      chk("after glitch rx_data", {24'd0, rx_data}, 32'h5A);
      chk("after glitch rx_valid", {31'd0, rx_valid}, 32'd1);

      // Ack coincident with delivery of the next byte: new byte loads, no overrun.
      fork
         send_frame(8'h96, 1'b1);
         begin
            repeat (156) @(negedge clk);
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      chk("ack+deliver rx_data", {24'd0, rx_data}, 32'h96);
      chk("ack+deliver rx_valid", {31'd0, rx_valid}, 32'd1);
      chk("ack+deliver overrun", {31'd0, overrun}, 32'd0);
      chk("ack+deliver cts", {31'd0, cts}, 32'd0);

      // Reset during data bit 4 with a byte still buffered.
      begin
         logic [7:0] pb;
         pb = 8'hE7;
         rxd = 1'b0;
         repeat (BC) @(negedge clk);
         for (int b = 0; b < 4; b++) begin
            rxd = pb[b];
            repeat (BC) @(negedge clk);
         end
         rxd = pb[4];
         repeat (BC / 2) @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("midreset rx_data", {24'd0, rx_data}, 32'h00);
      chk("midreset rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("midreset overrun", {31'd0, overrun}, 32'd0);
      chk("midreset cts", {31'd0, cts}, 32'd1);
      rst = 1'b1;
      rxd = 1'b1;
      repeat (3 * BC) @(negedge clk);
      chk("midreset no stray byte", {31'd0, rx_valid}, 32'd0);
      send_frame(8'h0F, 1'b1);
      repeat (4) @(negedge clk);
      chk("post reset rx_data", {24'd0, rx_data}, 32'h0F);
      chk("post reset rx_valid", {31'd0, rx_valid}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
